// File: rtl/mult_error_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_error_sweep_ctrl
// Purpose  : Exhaustive error sweep for one combinational approximate
//            multiplier. It presents every (x,y) pair in order, compares the
//            returned product with the exact product, and accumulates the
//            error count, the saturating sum of error distance and the
//            maximum error distance.
// Revision : 1.0 - initial release
// ============================================================================
module mult_error_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     mul_x,
    output logic [WIDTH-1:0]     mul_y,
    output logic                 mul_valid,
    input  logic [2*WIDTH:0]     mul_prod,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_count,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [2*WIDTH:0]     max_ed
);

    localparam int c_ED_W  = 2 * WIDTH + 1;
    localparam int c_SUM_W = ((ACC_W > c_ED_W) ? ACC_W : c_ED_W) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [WIDTH-1:0]    r_mul_x;
    logic [WIDTH-1:0]    r_mul_y;
    logic                r_mul_valid;
    logic                r_busy;
    logic                r_done;
    logic [c_ED_W-1:0]   r_err_count;
    logic [ACC_W-1:0]    r_sum_ed;
    logic [c_ED_W-1:0]   r_max_ed;

    // Stage-1 capture of the multiplier result and the matching exact product
    logic                r_s1_valid;
    logic [c_ED_W-1:0]   r_s1_prod;
    logic [c_ED_W-1:0]   r_s1_exact;

    logic [2*WIDTH-1:0]  w_exact;
    logic [2*WIDTH-1:0]  w_pair_next;
    logic                w_last_pair;
    logic                w_abort_run;
    logic [c_ED_W-1:0]   w_ed;
    logic [c_SUM_W-1:0]  w_sum_full;
    logic [ACC_W-1:0]    w_sum_sat;

    // Exact reference product, error distance and saturating sum
    always_comb begin
        w_exact     = {{WIDTH{1'b0}}, r_mul_x} * {{WIDTH{1'b0}}, r_mul_y};
        w_pair_next = {r_mul_x, r_mul_y} + (2*WIDTH)'(1);
        w_last_pair = (&r_mul_x) & (&r_mul_y);
        w_abort_run = abort & ((r_state == c_ISSUE) | (r_state == c_DRAIN));
        w_ed        = (r_s1_prod >= r_s1_exact) ? (r_s1_prod - r_s1_exact)
                                                : (r_s1_exact - r_s1_prod);
        w_sum_full  = c_SUM_W'(r_sum_ed) + c_SUM_W'(w_ed);
        w_sum_sat   = (w_sum_full[c_SUM_W-1:ACC_W] != '0) ? {ACC_W{1'b1}}
                                                          : w_sum_full[ACC_W-1:0];
    end

    // Sequencer FSM, two-stage compare pipeline and metric accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_mul_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_prod   <= '0;
            r_s1_exact  <= '0;
        end else begin
            // Stage 1: sample the pair presented during the cycle just ending
            r_s1_valid <= r_mul_valid;
            r_s1_prod  <= mul_prod;
            r_s1_exact <= {1'b0, w_exact};

            // Stage 2: fold one result into the metrics unless aborting now
            if (r_s1_valid && !w_abort_run) begin
                if (w_ed != '0) begin
                    r_err_count <= r_err_count + c_ED_W'(1);
                end
                r_sum_ed <= w_sum_sat;
                if (w_ed > r_max_ed) begin
                    r_max_ed <= w_ed;
                end
            end

            case (r_state)
                c_IDLE, c_DONE: begin
                    // abort alongside start suppresses the sweep entirely
                    if (start && !abort) begin
                        r_err_count <= '0;
                        r_sum_ed    <= '0;
                        r_max_ed    <= '0;
                        r_done      <= 1'b0;
                        r_mul_x     <= '0;
                        r_mul_y     <= '0;
                        r_mul_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (abort) begin
                        r_mul_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b0;
                        r_s1_valid  <= 1'b0;
                        r_state     <= c_IDLE;
                    end else begin
                        {r_mul_x, r_mul_y} <= w_pair_next;
                        if (w_last_pair) begin
                            r_mul_valid <= 1'b0;
                            r_state     <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    // The final pair is accumulated on this same edge
                    if (abort) begin
                        r_busy     <= 1'b0;
                        r_done     <= 1'b0;
                        r_s1_valid <= 1'b0;
                        r_state    <= c_IDLE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign mul_valid = r_mul_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_count = r_err_count;
    assign sum_ed    = r_sum_ed;
    assign max_ed    = r_max_ed;

endmodule
`default_nettype wire

// File: tb/tb_mult_error_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_error_sweep_ctrl
// Purpose  : Directed and randomized bench for mult_error_sweep_ctrl with
//            WIDTH=4. Two instances share control: one with a wide
//            accumulator, one with ACC_W=8 to exercise sum saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_error_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    int         mode;
    logic [8:0] err_tab [256];

    logic [3:0]  xa, ya, xb, yb;
    logic        va, vb, busy_a, busy_b, done_a, done_b;
    logic [8:0]  prod_a, prod_b, ec_a, ec_b, mx_a, mx_b;
    logic [47:0] sum_a;
    logic [7:0]  sum_b;

    int vectors    = 0;
    int miscompares = 0;
    int mon_k, mon_bad;

    always #5 clk = ~clk;

    // Behavioural multiplier variants selected by mode
    function automatic logic [8:0] calc_prod(input int m, input logic [3:0] x,
                                             input logic [3:0] y, input logic [8:0] e);
        logic [8:0] p;
        p = 9'(x) * 9'(y);
        case (m)
            0:       calc_prod = p;
            1:       calc_prod = p + 9'd1;
            2:       calc_prod = p & 9'h1FE;
            3:       calc_prod = 9'd0;
            default: calc_prod = p + e;
        endcase
    endfunction

    assign prod_a = calc_prod(mode, xa, ya, err_tab[{xa, ya}]);
    assign prod_b = calc_prod(mode, xb, yb, err_tab[{xb, yb}]);

    mult_error_sweep_ctrl #(.WIDTH(4), .ACC_W(48)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mul_x(xa), .mul_y(ya), .mul_valid(va), .mul_prod(prod_a),
        .busy(busy_a), .done(done_a), .err_count(ec_a), .sum_ed(sum_a), .max_ed(mx_a)
    );

    mult_error_sweep_ctrl #(.WIDTH(4), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mul_x(xb), .mul_y(yb), .mul_valid(vb), .mul_prod(prod_b),
        .busy(busy_b), .done(done_b), .err_count(ec_b), .sum_ed(sum_b), .max_ed(mx_b)
    );

    // Order monitor: pairs must appear as (0,0),(0,1)...(15,15)
    always @(negedge clk) begin
        if (va) begin
            if ({xa, ya} !== 8'(mon_k)) mon_bad = mon_bad + 1;
            mon_k = mon_k + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference metrics over the first npairs pairs in sweep order
    task automatic ref_metrics(input int m, input int npairs, input longint cap,
                               output longint ec, output longint sm, output longint mx);
        ec = 0; sm = 0; mx = 0;
        for (int k = 0; k < npairs; k++) begin
            int x, y, p, e, d;
            x = k / 16;
            y = k % 16;
            p = int'(calc_prod(m, 4'(x), 4'(y), err_tab[k]));
            e = x * y;
            d = (p > e) ? p - e : e - p;
            if (d != 0) ec++;
            sm = sm + d;
            if (sm > cap) sm = cap;
            if (d > mx) mx = d;
        end
    endtask

    task automatic chk_metrics(input string tag, input int m, input int npairs);
        longint ec, sm, mx;
        ref_metrics(m, npairs, 64'h0000_FFFF_FFFF_FFFF, ec, sm, mx);
        chk({tag, "_ec_a"},  64'(ec_a),  64'(ec));
        chk({tag, "_sum_a"}, 64'(sum_a), 64'(sm));
        chk({tag, "_max_a"}, 64'(mx_a),  64'(mx));
        ref_metrics(m, npairs, 255, ec, sm, mx);
        chk({tag, "_ec_b"},  64'(ec_b),  64'(ec));
        chk({tag, "_sum_b"}, 64'(sum_b), 64'(sm));
        chk({tag, "_max_b"}, 64'(mx_b),  64'(mx));
    endtask

    task automatic full_sweep(input string tag, input int m);
        int cyc;
        mode    = m;
        mon_k   = 0;
        mon_bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy_a && cyc < 2000) begin
            cyc++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'd257);
        chk({tag, "_done_a"}, 64'(done_a), 64'd1);
        chk({tag, "_done_b"}, 64'(done_b), 64'd1);
        chk({tag, "_busy_b"}, 64'(busy_b), 64'd0);
        chk({tag, "_pairs_seen"}, 64'(mon_k), 64'd256);
        chk({tag, "_pair_order"}, 64'(mon_bad), 64'd0);
        chk_metrics(tag, m, 256);
    endtask

    // Start, run until the abort edge lands at E0+d, then check partial metrics
    task automatic abort_run(input string tag, input int m, input int d, input bit poke_start);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < d; i++) begin
            start = (poke_start && i == 4);
            tick();
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_done"}, 64'(done_a), 64'd0);
        chk({tag, "_valid"}, 64'(va), 64'd0);
        chk_metrics(tag, m, d - 2);
        repeat (3) tick();
        chk({tag, "_ec_hold"}, 64'(ec_a), 64'(ec_b));
        chk_metrics({tag, "_hold"}, m, d - 2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
        mon_k = 0; mon_bad = 0;
        for (int k = 0; k < 256; k++) err_tab[k] = 9'd0;
        tick();
        tick();
        chk("rst_busy",  64'(busy_a), 64'd0);
        chk("rst_done",  64'(done_a), 64'd0);
        chk("rst_valid", 64'(va), 64'd0);
        chk("rst_xy",    64'({xa, ya}), 64'd0);
        chk("rst_ec",    64'(ec_a), 64'd0);
        chk("rst_sum",   64'(sum_a), 64'd0);
        chk("rst_max",   64'(mx_a), 64'd0);
        rst = 1'b0;
        tick();

        // start with abort in IDLE: nothing happens
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_idle_busy",  64'(busy_a), 64'd0);
        chk("sa_idle_valid", 64'(va), 64'd0);
        tick();
        chk("sa_idle_busy2", 64'(busy_a), 64'd0);

        full_sweep("exact", 0);
        full_sweep("plus1", 1);
        full_sweep("bit0", 2);
        full_sweep("bit0_rerun", 2);

        // start with abort in DONE: results held, done stays high
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_done_busy", 64'(busy_a), 64'd0);
        chk("sa_done_done", 64'(done_a), 64'd1);
        chk_metrics("sa_done", 2, 256);

        full_sweep("zero", 3);

        // Randomized error table
        for (int k = 0; k < 256; k++)
            err_tab[k] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'd0;
        full_sweep("rand", 4);

        abort_run("abort10", 1, 10, 1'b1);
        abort_run("abort_rand", 4, int'($urandom_range(3, 250)), 1'b0);

        // Reset in the middle of a sweep zeroes everything
        mode  = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy",  64'(busy_a), 64'd0);
        chk("midrst_valid", 64'(va), 64'd0);
        chk("midrst_xy",    64'({xa, ya}), 64'd0);
        chk("midrst_done",  64'(done_a), 64'd0);
        chk_metrics("midrst", 1, 0);
        repeat (3) tick();
        chk("midrst_idle",  64'(busy_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_error_sweep_ctrl.md
Name: mult_error_sweep_ctrl

Overview:
Sequencer for exhaustive error characterisation of one approximate multiplier instance (2-step, truncated or otherwise, with any final adder). It drives every (x,y) operand pair onto the multiplier's inputs and samples the returned product. It compares that product against an internally computed exact product and accumulates error metrics: error count, sum of error distance, maximum error distance. It sits between a host/testbench control interface and one combinational multiplier top.

Parameters:
WIDTH, 8, operand width; multiplier product port is 2*WIDTH+1 bits
ACC_W, 48, width of error-distance sum accumulator

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-high
start  input  1  pulse; begins a sweep when idle
abort  input  1  pulse; terminates a running sweep
mul_x  output  WIDTH  operand x to multiplier (registered)
mul_y  output  WIDTH  operand y to multiplier (registered)
mul_valid  output  1  mul_x/mul_y hold a pair under test
mul_prod  input  2*WIDTH+1  product returned combinationally by multiplier
busy  output  1  sweep in progress
done  output  1  sweep completed; held until next accepted start or rst
err_count  output  2*WIDTH+1  number of pairs with mul_prod != exact
sum_ed  output  ACC_W  sum of |mul_prod - exact|, saturating
max_ed  output  2*WIDTH+1  maximum |mul_prod - exact|

Behaviour:
- Reset: state IDLE; mul_x=mul_y=0, mul_valid=0, busy=0, done=0, err_count=0, sum_ed=0, max_ed=0; pipeline valids cleared. rst mid-sweep aborts immediately with these values.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + start (abort low) at edge E0: clear err_count/sum_ed/max_ed/done, mul_x=mul_y=0, mul_valid=1, busy=1, go ISSUE.
- start and abort in same cycle while IDLE/DONE: abort wins; no sweep begins, outputs unchanged.
- ISSUE: each edge advances the pair. mul_y increments; on mul_y wrap from all-ones to 0, mul_x increments. Pair k (k = x*2^WIDTH + y) is presented in the cycle after edge E0+k. After the pair (all-ones, all-ones) is presented, the next edge sets mul_valid=0 and enters DRAIN. No pair is skipped or repeated.
- Pipeline, stage 1: at the edge ending the cycle in which a pair is presented, capture mul_prod, the exact product mul_x*mul_y (2*WIDTH bits, zero-extended to 2*WIDTH+1) and a valid bit.
- Pipeline, stage 2: next edge computes ed = |prod - exact| unsigned. If ed != 0 then err_count += 1. sum_ed += ed, saturating at all-ones. max_ed = max(max_ed, ed).
- Timing: with N = 2^(2*WIDTH), the last pair is accumulated at edge E0+N+1. At that same edge the state moves DRAIN->DONE, busy=0 and done=1. busy is high for exactly N+1 cycles.
- DONE: metrics held stable. A start re-runs the sweep as from IDLE.
- start while busy: ignored.
- abort while busy: next edge sets mul_valid=0, busy=0 and done=0, and goes to IDLE. In-flight pipeline entries are discarded. Metrics hold the partial values accumulated before the abort edge.
- err_count width holds N exactly (no overflow). sum_ed saturation is only reachable when ACC_W < 4*WIDTH+1.
- All outputs are registered. mul_prod is used only via the stage-1 register.

Test Plan:
- WIDTH=4, multiplier model returns exact x*y; start pulse -> busy high 257 cycles, done=1, err_count=0, sum_ed=0, max_ed=0.
- WIDTH=4, model returns x*y+1 -> err_count=256, sum_ed=256, max_ed=1. Monitor confirms all 256 pairs seen once each, in order (0,0),(0,1)...(15,15).
- WIDTH=4, model returns x*y with bit0 forced 0 -> err_count=64 (x,y both odd), sum_ed=64, max_ed=1. Then a second start without rst gives identical results.
- WIDTH=4, ACC_W=8, model returns 0 -> sum_ed saturates at 255. max_ed=225, err_count=225 (all pairs except those with x=0 or y=0: 256-31).
- Abort 10 cycles after start, model returns x*y+1 -> busy falls next edge, done=0, err_count=sum_ed=8 (pairs accumulated before abort edge). start during run ignored; rst mid-run zeroes all outputs.
- start and abort asserted together in IDLE -> no sweep; busy stays 0, mul_valid stays 0.
